// File: rtl/rr_hold_arbiter_if.sv
// rr_hold_arbiter_if: requester/resource signals shared between the arbiter and its users
interface rr_hold_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS-1:0]         req_i;
    logic                         done_i;
    logic [NUM_PORTS-1:0]         gnt_o;
    logic                         gnt_valid_o;
    logic [$clog2(NUM_PORTS)-1:0] gnt_id_o;
    modport master (output req_i, done_i, input gnt_o, gnt_valid_o, gnt_id_o);
    modport slave  (input req_i, done_i, output gnt_o, gnt_valid_o, gnt_id_o);
endinterface

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: registered round-robin arbiter with grant hold and a contended hold budget
module rr_hold_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_HOLD  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    rr_hold_arbiter_if.slave    bus
);
    localparam int IW = $clog2(NUM_PORTS);
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    typedef enum logic {S_IDLE, S_GRANT} state_t;
    state_t               r_state, w_state;
    logic [NUM_PORTS-1:0] r_gnt, w_gnt;
    logic                 r_valid, w_valid;
    logic [IW-1:0]        r_id, w_id, r_ptr, w_ptr, w_win;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic                 w_found, w_others, w_rel;
    // descending scan so the port closest above ptr is written last and wins
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            int s;
            s = int'(r_ptr) + k;
            if (s >= NUM_PORTS) s = s - NUM_PORTS;
            if (bus.req_i[s]) begin
                w_found = 1'b1;
                w_win   = IW'(s);
            end
        end
    end
    assign w_others = |(bus.req_i & ~r_gnt);
    assign w_rel    = !bus.req_i[r_id] || bus.done_i || (r_cnt == CW'(MAX_HOLD - 1) && w_others);
    always_comb begin
        w_state = r_state;
        w_gnt   = r_gnt;
        w_valid = r_valid;
        w_id    = r_id;
        w_ptr   = r_ptr;
        w_cnt   = r_cnt;
        if (r_state == S_IDLE) begin
            if (w_found) begin
                w_state = S_GRANT;
                w_gnt   = {{(NUM_PORTS-1){1'b0}}, 1'b1} << w_win;
                w_valid = 1'b1;
                w_id    = w_win;
                w_cnt   = '0;
                w_ptr   = (w_win == IW'(NUM_PORTS - 1)) ? '0 : w_win + 1'b1;
            end
        end else if (w_rel) begin
            w_state = S_IDLE;
            w_gnt   = '0;
            w_valid = 1'b0;
            w_id    = '0;
            w_cnt   = '0;
        end else begin
            w_cnt = (r_cnt == CW'(MAX_HOLD - 1)) ? r_cnt : r_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_gnt   <= w_gnt;
            r_valid <= w_valid;
            r_id    <= w_id;
            r_ptr   <= w_ptr;
            r_cnt   <= w_cnt;
        end
    end
    assign bus.gnt_o       = r_gnt;
    assign bus.gnt_valid_o = r_valid;
    assign bus.gnt_id_o    = r_id;
endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Registered round-robin arbiter that shares one downstream resource among NUM_PORTS requesters. It issues a one-hot grant that is held until the owner releases, signals done, or exceeds a hold budget while others wait. It sits between requester ports and the shared resource. It replaces the purely combinational fixed-priority grant wherever fairness and grant stability across cycles are required.

## Interface
- NUM_PORTS, 4: number of requester ports; must be at least 2.
- MAX_HOLD, 16: maximum contended grant length in cycles; must be at least 1.
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- req_i  in  NUM_PORTS  per-port request level; held high while the port wants or uses the resource.
- done_i  in  1  resource-side pulse; the current owner has finished.
- gnt_o  out  NUM_PORTS  registered one-hot grant; all-zero when no port is granted.
- gnt_valid_o  out  1  registered; equals the OR of gnt_o.
- gnt_id_o  out  $clog2(NUM_PORTS)  binary index of the current owner; 0 when gnt_valid_o=0.

## Operation
- Two-state FSM: IDLE and GRANT.
- Internal state:
  - rotating priority pointer ptr, $clog2(NUM_PORTS) bits;
  - hold counter cnt, $clog2(MAX_HOLD) bits, minimum 1 bit.
- IDLE:
  - If req_i is nonzero, select the first set bit searching upward from ptr with wrap-around: ptr, ptr+1, …, NUM_PORTS-1, 0, …, ptr-1.
  - At the edge: load gnt_o and gnt_id_o, set gnt_valid_o=1, cnt=0, ptr=(winner+1) mod NUM_PORTS, and go to GRANT.
  - If req_i is zero, stay in IDLE with outputs at zero.
- GRANT, release conditions (any one):
  - (a) req_i[owner]=0;
  - (b) done_i=1;
  - (c) cnt==MAX_HOLD-1 and any other req_i bit is 1.
- On release: at the edge, clear gnt_o, gnt_valid_o and gnt_id_o, and go to IDLE. Every handover has one bubble cycle.
- Without release: stay in GRANT and hold the outputs. cnt increments and saturates at MAX_HOLD-1. With no contender, the grant persists indefinitely.
- Simultaneous release conditions are one release. Requests by other ports never preempt the owner except through (c).
- done_i is ignored in IDLE.
- ptr is updated only when a grant is issued, not on release.
- Every output comes directly from a flop. There is no combinational path from the inputs to the outputs.

## Timing
- Reset: synchronous. Any edge with rst_i=1 forces IDLE, gnt_o=0, gnt_valid_o=0, gnt_id_o=0, ptr=0, cnt=0. This applies mid-grant as well; no grant survives reset.
- Request-to-grant latency: a request sampled at edge k in IDLE gives gnt_o valid after edge k, so the grant is visible in the cycle following the edge.
- Release latency: a release condition sampled at edge m clears gnt_o after edge m. The earliest next grant is after edge m+1.
- Contended hold: the grant lasts exactly MAX_HOLD cycles when condition (c) is the cause. With MAX_HOLD=1, a contended grant lasts one cycle.
- Handover period under full load with immediate done: 2 cycles per grant (grant cycle plus bubble).
- Invariant: gnt_o is one-hot or zero in every cycle, and gnt_id_o matches gnt_o.

## Test plan
- Reset: hold rst_i for 3 cycles with req_i=4'b1111 -> gnt_o=0, gnt_valid_o=0, gnt_id_o=0 throughout. The first grant after reset release goes to port 0.
- Single requester: req_i=4'b0100 from reset -> gnt_o=4'b0100 and gnt_id_o=2 one edge later. Drop req_i[2] -> gnt_o=0 the next edge.
- Fairness: req_i=4'b1111 held, done_i pulsed in each grant cycle -> grant order is ports 0,1,2,3,0,1, each lasting 1 cycle and separated by a 1-cycle zero bubble.
- Hold budget (MAX_HOLD=4): port1 holds req and port3 requests from the same cycle -> gnt_o=4'b0010 for exactly 4 cycles, then 1 bubble, then gnt_o=4'b1000.
- Uncontested hold: only req_i[0] is high for 20 cycles with MAX_HOLD=4 -> gnt_o=4'b0001 continuously for 20 cycles, with no bubble.
- Reset mid-grant and pointer wrap:
  - With port3 granted, assert rst_i for one cycle -> gnt_o=0 after that edge.
  - Then req_i=4'b1010 -> port1 wins, because ptr=0.
  - Release port1 -> port3 wins next.
